// File: rtl/fifo_pkg.sv
// Shared sizing helpers for the first-word-fall-through instruction FIFO.
package fifo_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_DEPTH = 5;

   // Pointers carry one extra wrap bit above the storage index.
   function automatic int ptr_w(input int depth);
      return depth + 1;
   endfunction

   function automatic int capacity(input int depth);
      return 1 << depth;
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// Storage for fwft_fifo: synchronous write port, asynchronous read port, contents not reset.
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic             aclk,
   input  logic             we,
   input  logic [DEPTH-1:0] waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [DEPTH-1:0] raddr,
   output logic [WIDTH-1:0] rdata
);

   localparam int CAP = capacity(DEPTH);

   logic [WIDTH-1:0] mem [CAP];

   always_ff @(posedge aclk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fwft_fifo.sv
// Single-clock show-ahead FIFO: head word is visible on r_data without a read strobe.
// Optional sticky overflow/underflow flags are built when FIFO_ERR_FLAGS_EN is defined.
module fwft_fifo
   import fifo_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic             aclk,
   input  logic             aresetn,
   input  logic             w_en,
   input  logic [WIDTH-1:0] w_data,
   input  logic             r_en,
   output logic [WIDTH-1:0] r_data,
   output logic             full,
   output logic             empty,
   output logic [DEPTH:0]   count,
   output logic             err_overflow,
   output logic             err_underflow
);

   localparam int PW = ptr_w(DEPTH);

   logic [PW-1:0]    wptr, rptr;
   logic [WIDTH-1:0] head;
   logic             push, pop;

   // Guards use the pre-edge flags, so a push into a full FIFO is dropped even
   // if the same edge pops, and a pop from empty is dropped even if it pushes.
   assign push = w_en && !full;
   assign pop  = r_en && !empty;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push) wptr <= wptr + PW'(1);
         if (pop)  rptr <= rptr + PW'(1);
      end
   end

   assign empty  = (wptr == rptr);
   assign full   = (wptr[DEPTH] != rptr[DEPTH]) && (wptr[DEPTH-1:0] == rptr[DEPTH-1:0]);
   assign count  = wptr - rptr;
   assign r_data = empty ? '0 : head;

   fifo_mem #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
   ) u_mem (
      .aclk (aclk),
      .we   (push),
      .waddr(wptr[DEPTH-1:0]),
      .wdata(w_data),
      .raddr(rptr[DEPTH-1:0]),
      .rdata(head)
   );

`ifdef FIFO_ERR_FLAGS_EN
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         err_overflow  <= 1'b0;
         err_underflow <= 1'b0;
      end else begin
         if (w_en && full)  err_overflow  <= 1'b1;
         if (r_en && empty) err_underflow <= 1'b1;
      end
   end

`ifndef SYNTHESIS
   always @(posedge aclk) begin
      if (aresetn && w_en && full)  $error("fwft_fifo: push while full");
      if (aresetn && r_en && empty) $error("fwft_fifo: pop while empty");
   end
`endif
`else
   assign err_overflow  = 1'b0;
   assign err_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fwft_fifo.sv
// Self-checking bench for fwft_fifo against a queue-based reference model.
module tb_fwft_fifo;

   localparam int WIDTH = 32;
   localparam int DEPTH = 5;
   localparam int CAP   = 1 << DEPTH;

   logic             aclk = 1'b0;
   logic             aresetn = 1'b0;
   logic             w_en = 1'b0;
   logic [WIDTH-1:0] w_data = '0;
   logic             r_en = 1'b0;
   logic [WIDTH-1:0] r_data;
   logic             full, empty;
   logic [DEPTH:0]   count;
   logic             err_overflow, err_underflow;

   fwft_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .aclk         (aclk),
      .aresetn      (aresetn),
      .w_en         (w_en),
      .w_data       (w_data),
      .r_en         (r_en),
      .r_data       (r_data),
      .full         (full),
      .empty        (empty),
      .count        (count),
      .err_overflow (err_overflow),
      .err_underflow(err_underflow)
   );

   always #5 aclk = ~aclk;

   int n_cmp = 0;
   int n_err = 0;

   logic [WIDTH-1:0] q[$];
   logic             m_ovf = 1'b0, m_unf = 1'b0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic chk_all(input string tag);
      logic [WIDTH-1:0] exp_head;
      exp_head = (q.size() > 0) ? q[0] : '0;
      chk({tag, ".empty"}, 64'(empty), 64'(q.size() == 0));
      chk({tag, ".full"},  64'(full),  64'(q.size() == CAP));
      chk({tag, ".count"}, 64'(count), 64'(q.size()));
      chk({tag, ".rdata"}, 64'(r_data), 64'(exp_head));
`ifdef FIFO_ERR_FLAGS_EN
      chk({tag, ".ovf"}, 64'(err_overflow),  64'(m_ovf));
      chk({tag, ".unf"}, 64'(err_underflow), 64'(m_unf));
`else
      chk({tag, ".ovf"}, 64'(err_overflow),  64'(0));
      chk({tag, ".unf"}, 64'(err_underflow), 64'(0));
`endif
   endtask

   // One clock: inputs driven between edges, model updated from pre-edge occupancy.
   task automatic cyc(input logic w, input logic [WIDTH-1:0] wd, input logic r, input string tag);
      int n;
      w_en = w; w_data = wd; r_en = r;
      @(posedge aclk);
      n = q.size();
      if (w && n == CAP) m_ovf = 1'b1;
      if (r && n == 0)   m_unf = 1'b1;
      if (r && n > 0)    void'(q.pop_front());
      if (w && n < CAP)  q.push_back(wd);
      #1;
      w_en = 1'b0; r_en = 1'b0;
      chk_all(tag);
   endtask

   task automatic drain();
      while (q.size() > 0) cyc(1'b0, '0, 1'b1, "drain");
   endtask

   task automatic do_reset();
      aresetn = 1'b0;
      q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
      #1;
      chk_all("reset");
      @(negedge aclk);
      aresetn = 1'b1;
   endtask

   initial begin
      #3;
      do_reset();
      repeat (2) cyc(1'b0, '0, 1'b0, "idle");

      cyc(1'b1, 32'hDEADBEEF, 1'b0, "push1");
      cyc(1'b0, '0, 1'b1, "pop1");

      for (int i = 0; i < CAP; i++) cyc(1'b1, WIDTH'(i), 1'b0, "fill");
      cyc(1'b1, 32'hFFFFFFFF, 1'b0, "push_full");
      for (int i = 0; i < CAP; i++) begin
         chk("order", 64'(r_data), 64'(i));
         cyc(1'b0, '0, 1'b1, "popall");
      end

      do_reset();
      for (int i = 0; i < CAP; i++) cyc(1'b1, $urandom, 1'b0, "fill2");
      cyc(1'b1, 32'hA5A5A5A5, 1'b1, "wr_rd_full");
      drain();
      cyc(1'b1, 32'h12345678, 1'b1, "wr_rd_empty");
      drain();

      do_reset();
      for (int i = 0; i < 20; i++) cyc(1'b1, 32'h100 + i, 1'b0, "wrapA");
      for (int i = 0; i < 20; i++) cyc(1'b0, '0, 1'b1, "wrapB");
      for (int i = 0; i < 20; i++) cyc(1'b1, 32'h200 + i, 1'b0, "wrapC");
      drain();

      for (int i = 0; i < 600; i++)
         cyc(1'b1 & ($urandom_range(0, 99) < 55), $urandom, ($urandom_range(0, 99) < 45), "rand");

      for (int i = 0; i < 7; i++) cyc(1'b1, $urandom, 1'b0, "midfill");
      #2;
      aresetn = 1'b0;
      q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
      #1;
      chk_all("async_rst");
      @(negedge aclk);
      aresetn = 1'b1;
      cyc(1'b1, 32'hCAFEF00D, 1'b0, "post_rst");
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fwft_fifo.md
Name: fwft_fifo

Overview:
- Synchronous single-clock first-word-fall-through (show-ahead) FIFO.
- Used by the video accelerator as its instruction queue: the AXI-Lite BRAM-style controller side pushes 32-bit instruction words, and the decoder peeks at and pops the head word.
- The head word is visible on r_data without a read strobe, so the consumer can decode before deciding to pop.

Parameters:
- WIDTH, 32: data word width in bits.
- DEPTH, 5: log2 of entry count; capacity is 2**DEPTH entries (32 by default).

Ports:
- aclk  input  1  clock; all state updates on its rising edge.
- aresetn  input  1  reset, asynchronous, active-low.
- w_en  input  1  push request for this cycle.
- w_data  input  WIDTH  word to push.
- r_en  input  1  pop request for this cycle.
- r_data  output  WIDTH  current head word (combinational peek).
- full  output  1  FIFO holds 2**DEPTH entries.
- empty  output  1  FIFO holds 0 entries.
- count  output  DEPTH+1  current occupancy, 0..2**DEPTH.
- err_overflow  output  1  sticky flag: push attempted while full (optional feature).
- err_underflow  output  1  sticky flag: pop attempted while empty (optional feature).

Behaviour:
- Storage:
  - Storage array of 2**DEPTH x WIDTH; not reset.
  - Write and read pointers are DEPTH+1 bits wide, with the MSB used as the wrap bit.
- Reset (asynchronous, takes effect immediately, including mid-operation): both pointers = 0, count = 0, empty = 1, full = 0, r_data = 0, error flags = 0. Stored contents are discarded logically.
- Push: when w_en && !full at a rising edge, mem[wptr[DEPTH-1:0]] <= w_data and wptr increments.
- Pop: when r_en && !empty at a rising edge, rptr increments.
- Guarding: full and empty are the pre-edge values.
  - A push while full is ignored, even if a pop occurs in the same cycle.
  - A pop while empty is ignored, even if a push occurs in the same cycle; the pushed word is still stored.
- Simultaneous accepted push and pop: both pointers advance and count is unchanged.
- Status flags:
  - empty = (wptr == rptr).
  - full = (wptr[DEPTH] != rptr[DEPTH]) && (wptr[DEPTH-1:0] == rptr[DEPTH-1:0]).
  - count = wptr - rptr, modulo 2**(DEPTH+1).
- Pointer wrap-around: natural binary rollover of the DEPTH+1-bit counters; the lower DEPTH bits index storage.
- r_data: combinational.
  - Not empty: r_data = mem[rptr[DEPTH-1:0]].
  - Empty: r_data = 0.
- Latency:
  - A pushed word appears on r_data and clears empty in the cycle after the push edge.
  - After a pop edge, the next word, or 0 with empty = 1, is visible in the following cycle.
- Flags are registered off pointers only; there is no combinational path from w_en or r_en to any output.

Optional Feature:
- Macro: FIFO_ERR_FLAGS_EN.
- Defined:
  - err_overflow sets at any edge with w_en && full; err_underflow sets at any edge with r_en && empty.
  - Both flags are sticky until reset.
  - A simulation-only $error is reported on each event.
- Undefined: err_overflow and err_underflow are tied to 0; no extra logic.

Decomposition:
- Shared package fifo_pkg: localparam helpers for pointer width (DEPTH+1) and capacity (1 << DEPTH); no typedefs required beyond these.
- Natural sub-module fifo_mem: 2**DEPTH x WIDTH array with a synchronous write port and an asynchronous read port.
- Pointer/flag logic stays in fwft_fifo.

Test Plan:
- Reset then idle -> empty = 1, full = 0, count = 0, r_data = 0.
- Push 0xDEADBEEF -> next cycle empty = 0, count = 1, r_data = 0xDEADBEEF without r_en. Pop -> empty = 1, r_data = 0.
- Push 32 words 0x0..0x1F -> full = 1, count = 32. A 33rd push of 0xFFFFFFFF is ignored (err_overflow = 1 with FIFO_ERR_FLAGS_EN). Pop all 32 -> values 0x0..0x1F in order.
- With the FIFO full, assert w_en and r_en together -> pop happens, push ignored, count = 31, full = 0.
- With the FIFO empty, assert w_en (0x12345678) and r_en together -> word stored, count = 1, r_data = 0x12345678 next cycle (err_underflow = 1 with the macro).
- Fill 20 words, pop 20, push 20 more (pointers wrap past index 31) -> correct FIFO order and count.
- Deassert aresetn asynchronously mid-fill -> empty = 1 and count = 0 immediately.
